// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register with a two-entry skid buffer.
// in_ready is registered, so decode never sees a combinational path from execute.
module id_ex_skid_reg #(
  parameter int DATAWIDTH = 32,
  parameter int REGADDRW  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_pc,
  input  logic [DATAWIDTH-1:0] in_op_a,
  input  logic [DATAWIDTH-1:0] in_op_b,
  input  logic [3:0]           in_alu_ctrl,
  input  logic [REGADDRW-1:0]  in_rd,
  input  logic [3:0]           in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_pc,
  output logic [DATAWIDTH-1:0] out_op_a,
  output logic [DATAWIDTH-1:0] out_op_b,
  output logic [3:0]           out_alu_ctrl,
  output logic [REGADDRW-1:0]  out_rd,
  output logic [3:0]           out_ctrl,
  output logic [1:0]           occupancy
);

  localparam int PW = 3*DATAWIDTH + 4 + REGADDRW + 4;
  // Bit range holding {alu_ctrl, rd, ctrl}; alu_ctrl and ctrl get cleared when emptied.
  localparam int ALU_LO = REGADDRW + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [PW-1:0]   main_q, main_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   in_payload;
  logic            push, pop;
  logic            load_main_in, load_main_skid, load_skid;

  assign in_payload = {in_pc, in_op_a, in_op_b, in_alu_ctrl, in_rd, in_ctrl};
  assign out_valid  = (state_q != EMPTY);
  assign in_ready   = in_ready_q;
  assign push       = in_valid & in_ready_q;
  assign pop        = out_valid & out_ready;
  assign occupancy  = 2'(state_q);

  assign {out_pc, out_op_a, out_op_b, out_alu_ctrl, out_rd, out_ctrl} = main_q;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A flush wins over every transfer; a same-cycle pop is simply consumed.
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
    in_ready_d = (state_d != TWO);
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (load_main_in) begin
      main_d = in_payload;
    end else if (load_main_skid) begin
      main_d = skid_q;
    end
    if (load_skid) begin
      skid_d = in_payload;
    end
    if (state_d == EMPTY) begin
      main_d[ALU_LO+3:ALU_LO] = 4'b0000;
      main_d[3:0]             = 4'b0000;
      skid_d[ALU_LO+3:ALU_LO] = 4'b0000;
      skid_d[3:0]             = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed self-checking bench for id_ex_skid_reg: reset, streaming, backpressure,
// flush, simultaneous push/pop and bit-exact payload pass-through.
module tb_id_ex_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic [3:0]  in_alu_ctrl;
  logic [4:0]  in_rd;
  logic [3:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic [3:0]  out_ctrl;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  id_ex_skid_reg #(.DATAWIDTH(32), .REGADDRW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .in_alu_ctrl(in_alu_ctrl), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_alu_ctrl(out_alu_ctrl), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle so outputs are sampled away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic rdy);
    in_valid  = 1'b1;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_op_a = '0; in_op_b = '0; in_alu_ctrl = '0; in_rd = '0; in_ctrl = '0;
    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_out_pc",    out_pc,         32'h0);
    checkOutput("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus();

    $display("[TB] streaming");
    in_ctrl = 4'b1000; in_alu_ctrl = 4'b0001;
    push(32'h00, 1'b1);
    applyStimulus();
    checkOutput("stream0_pc",  out_pc, 32'h00);
    checkOutput("stream0_occ", 32'(occupancy), 32'd1);
    checkOutput("stream0_rdy", 32'(in_ready), 32'd1);
    push(32'h04, 1'b1);
    applyStimulus();
    checkOutput("stream1_pc",  out_pc, 32'h04);
    checkOutput("stream1_occ", 32'(occupancy), 32'd1);
    checkOutput("stream1_rdy", 32'(in_ready), 32'd1);
    push(32'h08, 1'b1);
    applyStimulus();
    checkOutput("stream2_pc",  out_pc, 32'h08);
    checkOutput("stream2_occ", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    applyStimulus();
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_occ",   32'(occupancy), 32'd0);
    checkOutput("drain_ctrl",  32'(out_ctrl), 32'd0);
    checkOutput("drain_alu",   32'(out_alu_ctrl), 32'd0);

    $display("[TB] backpressure");
    push(32'h10, 1'b0);
    applyStimulus();
    checkOutput("bp0_pc",  out_pc, 32'h10);
    checkOutput("bp0_occ", 32'(occupancy), 32'd1);
    push(32'h14, 1'b0);
    applyStimulus();
    checkOutput("bp1_occ", 32'(occupancy), 32'd2);
    checkOutput("bp1_rdy", 32'(in_ready), 32'd0);
    checkOutput("bp1_pc",  out_pc, 32'h10);
    push(32'h99, 1'b0);
    applyStimulus();
    checkOutput("bp_hold_occ", 32'(occupancy), 32'd2);
    checkOutput("bp_hold_pc",  out_pc, 32'h10);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checkOutput("bp_pop0_pc", out_pc, 32'h10);
    applyStimulus();
    checkOutput("bp_pop1_pc",  out_pc, 32'h14);
    checkOutput("bp_pop1_occ", 32'(occupancy), 32'd1);
    checkOutput("bp_pop1_rdy", 32'(in_ready), 32'd1);
    applyStimulus();
    checkOutput("bp_empty_occ", 32'(occupancy), 32'd0);

    $display("[TB] flush");
    push(32'h40, 1'b0);
    applyStimulus();
    push(32'h44, 1'b0);
    applyStimulus();
    checkOutput("fl_full_occ", 32'(occupancy), 32'd2);
    flush = 1'b1;
    push(32'h20, 1'b0);
    applyStimulus();
    checkOutput("fl_occ",   32'(occupancy), 32'd0);
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_rdy",   32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    applyStimulus();
    checkOutput("fl_after_occ", 32'(occupancy), 32'd0);
    push(32'h50, 1'b0);
    applyStimulus();
    checkOutput("fl1_pre_pc", out_pc, 32'h50);
    flush = 1'b1;
    push(32'h24, 1'b0);
    applyStimulus();
    checkOutput("fl1_occ",   32'(occupancy), 32'd0);
    checkOutput("fl1_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    applyStimulus();
    checkOutput("fl1_after_occ", 32'(occupancy), 32'd0);

    $display("[TB] push and pop in ONE");
    push(32'h30, 1'b0);
    applyStimulus();
    checkOutput("pp0_pc", out_pc, 32'h30);
    push(32'h34, 1'b1);
    applyStimulus();
    checkOutput("pp1_pc",  out_pc, 32'h34);
    checkOutput("pp1_occ", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    applyStimulus();
    checkOutput("pp2_occ", 32'(occupancy), 32'd0);

    $display("[TB] payload pass-through");
    in_op_a = 32'hFFFF_FFF8; in_op_b = 32'h2; in_alu_ctrl = 4'b0111;
    in_ctrl = 4'b1000; in_rd = 5'd7;
    push(32'h70, 1'b0);
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("pl_op_a", out_op_a, 32'hFFFF_FFF8);
    checkOutput("pl_op_b", out_op_b, 32'h2);
    checkOutput("pl_alu",  32'(out_alu_ctrl), 32'h7);
    checkOutput("pl_ctrl", 32'(out_ctrl), 32'h8);
    checkOutput("pl_rd",   32'(out_rd), 32'd7);
    checkOutput("pl_sra",  32'($signed(out_op_a) >>> out_op_b[4:0]), 32'hFFFF_FFFE);
    out_ready = 1'b1;
    applyStimulus();
    out_ready = 1'b0;

    $display("[TB] reset mid-stream");
    push(32'h80, 1'b0);
    applyStimulus();
    push(32'h84, 1'b0);
    applyStimulus();
    in_valid = 1'b0;
    checkOutput("mr_full_occ", 32'(occupancy), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mr_valid", 32'(out_valid), 32'd0);
    checkOutput("mr_rdy",   32'(in_ready), 32'd1);
    checkOutput("mr_occ",   32'(occupancy), 32'd0);
    checkOutput("mr_pc",    out_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    push(32'h60, 1'b0);
    applyStimulus();
    checkOutput("mr_post_pc",  out_pc, 32'h60);
    checkOutput("mr_post_occ", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
